// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU and the blocks that drive it.
//   - 3-bit ALU opcodes
//   - mod_control FSM state encoding
package alu_pkg;

    localparam logic [2:0] AluAnd  = 3'b000;
    localparam logic [2:0] AluOr   = 3'b001;
    localparam logic [2:0] AluXor  = 3'b010;
    localparam logic [2:0] AluNor  = 3'b011;
    localparam logic [2:0] AluLess = 3'b100;
    localparam logic [2:0] AluAdd  = 3'b101;
    localparam logic [2:0] AluSub  = 3'b110;
    localparam logic [2:0] AluMod  = 3'b111;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCheck = 2'd1,
        StSub   = 2'd2,
        StDone  = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/mod_control.sv
// mod_control: computes dividend mod divisor by repeated subtraction on an
// external combinational ALU. The block alternates between a LESS compare
// (remainder < divisor?) and a SUB step until the compare reports true.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       request pulse, accepted only in the idle state
//   dividend    signed operand, must be >= 0
//   divisor     signed operand, must be > 0
//   alu_a/b     operands to the external ALU (zero outside CHECK/SUB)
//   alu_op      opcode to the external ALU (zero outside CHECK/SUB)
//   alu_result  combinational ALU result
//   busy        high while the operation is iterating
//   done        one-cycle completion pulse
//   err         illegal operands; valid with done, held until next start
//   remainder   result remainder, held until next start
//   quotient    number of subtractions performed, held until next start
module mod_control
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] quotient
);

    ctrl_state_e      state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic             err_q, err_d;
    logic             operands_legal;

    // Legal: divisor strictly positive, dividend non-negative (sign bits clear).
    assign operands_legal = !divisor[WIDTH-1] && (divisor != '0) && !dividend[WIDTH-1];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quot_d  = quot_q;
        err_d   = err_q;
        alu_a   = '0;
        alu_b   = '0;
        alu_op  = AluAnd;

        case (state_q)
            StIdle: begin
                if (start) begin
                    rem_d  = dividend;
                    quot_d = '0;
                    err_d  = 1'b0;
                    if (operands_legal) begin
                        div_d   = divisor;
                        state_d = StCheck;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StCheck: begin
                alu_a  = rem_q;
                alu_b  = div_q;
                alu_op = AluLess;
                // Bit 0 of a LESS result is the compare outcome.
                state_d = alu_result[0] ? StDone : StSub;
            end
            StSub: begin
                alu_a   = rem_q;
                alu_b   = div_q;
                alu_op  = AluSub;
                rem_d   = alu_result;
                quot_d  = quot_q + {{(WIDTH-1){1'b0}}, 1'b1};
                state_d = StCheck;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            rem_q   <= '0;
            div_q   <= '0;
            quot_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quot_q  <= quot_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q == StCheck) || (state_q == StSub);
    assign done      = (state_q == StDone);
    assign err       = err_q;
    assign remainder = rem_q;
    assign quotient  = quot_q;

endmodule

// File: doc/mod_control.md
MOD_CONTROL -- requirements
Module: mod_control

Interface
REQ-001 The block SHALL use parameter WIDTH, default 32, meaning the operand, remainder and quotient width, equal to the ALU width.
REQ-002 clk  input  1  the single clock; all state SHALL change on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; operands are sampled on the rising edge where start=1 and busy=0.
REQ-005 dividend  input  WIDTH  signed two's-complement dividend.
REQ-006 divisor  input  WIDTH  signed two's-complement divisor.
REQ-007 alu_a  output  WIDTH  A operand driven to the external ALU.
REQ-008 alu_b  output  WIDTH  B operand driven to the external ALU.
REQ-009 alu_op  output  3  opcode driven to the external ALU.
REQ-010 alu_result  input  WIDTH  combinational ALU result for the current alu_a, alu_b and alu_op.
REQ-011 busy  output  1  high from the cycle after start is accepted until done.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  valid with done; indicates illegal operands.
REQ-014 remainder  output  WIDTH  registered result.
REQ-015 quotient  output  WIDTH  registered subtraction count.

Function
REQ-016 The block SHALL compute dividend mod divisor by repeated ALU subtraction, acting as the initiator that drives the ALU's less (100) and subtract (110) operations.
REQ-017 The FSM SHALL have exactly the states IDLE, CHECK, SUB and DONE.
REQ-018 IDLE: on start with divisor > 0 and dividend >= 0, the block SHALL load rem_reg=dividend, div_reg=divisor and quotient=0, then go to CHECK; otherwise it SHALL load rem_reg=dividend and quotient=0, set err=1, and go to DONE.
REQ-019 CHECK: the block SHALL drive alu_a=rem_reg, alu_b=div_reg and alu_op=100; if alu_result[0]=1 it SHALL go to DONE, else to SUB.
REQ-020 SUB: the block SHALL drive alu_a=rem_reg, alu_b=div_reg and alu_op=110; at the clock edge it SHALL set rem_reg=alu_result and quotient=quotient+1, then go to CHECK.
REQ-021 DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
REQ-022 In IDLE and DONE, alu_a, alu_b and alu_op SHALL be driven to 0.
REQ-023 Latency: cycle 1 is the cycle after the start edge; for legal operands with quotient q, done SHALL be high in cycle 2q+2; for illegal operands, done SHALL be high in cycle 1.
REQ-024 remainder, quotient and err SHALL hold their values after done until the next accepted start; err SHALL clear on any accepted start.
REQ-025 A start seen while busy=1 or during DONE SHALL be ignored, with no queuing.
REQ-026 Dividend < divisor SHALL complete with q=0 and remainder=dividend in cycle 2.
REQ-027 Dividend = 0 SHALL give remainder 0 and quotient 0.
REQ-028 Quotient arithmetic is WIDTH-bit; wrap is impossible for legal operands, and no wrap check is required.
REQ-029 The block SHALL treat the ALU as purely combinational and SHALL NOT register alu_a, alu_b or alu_op beyond the state and data registers.

Reset
REQ-030 When reset=1 at a rising edge, the block SHALL enter IDLE and clear rem_reg, div_reg, remainder, quotient, err, done and busy to 0, regardless of the current state.
REQ-031 Reset SHALL take priority over start in the same cycle; an operation interrupted by reset SHALL be abandoned with no done pulse.

Structure
REQ-032 The ALU opcode constants (AND 000, OR 001, XOR 010, NOR 011, LESS 100, ADD 101, SUB 110, MOD 111) and the FSM state encoding SHALL live in the shared package alu_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the ALU SHALL be instantiated only by the bench or the enclosing datapath.

Verification
REQ-034 Bench SHALL connect mod_control to the team's 32-bit ALU (or a behavioural model with identical opcodes) and check every alu_op issued.
REQ-035 Scenario: dividend=7, divisor=3 -> done in cycle 6, remainder=1, quotient=2, err=0.
REQ-036 Scenario: dividend=2, divisor=5 -> done in cycle 2, remainder=2, quotient=0.
REQ-037 Scenario: divisor=0, and separately dividend=-4 -> done in cycle 1, err=1, remainder=dividend, quotient=0.
REQ-038 Scenario: dividend=100, divisor=7; reset asserted in cycle 5 -> next cycle IDLE, all outputs 0, and no done pulse.
REQ-039 Scenario: start re-pulsed in cycle 3 of (20 mod 6) -> ignored; result remainder=2, quotient=3, done in cycle 8.
REQ-040 Scenario: dividend=0x7FFFFFFF, divisor=0x40000000 -> remainder=0x3FFFFFFF, quotient=1, done in cycle 4.
